// File: rtl/plot_pkg.sv
// Shared definitions for the plot arbiter and the game controller: FSM encoding,
// default tile/coordinate sizes and a counter-width helper.
package plot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } plot_state_t;

  localparam int PLOT_TILE_W  = 4;
  localparam int PLOT_TILE_H  = 4;
  localparam int PLOT_X_W     = 8;
  localparam int PLOT_Y_W     = 7;
  localparam int PLOT_COLOR_W = 3;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plot_arb_pick.sv
// Combinational winner select: fixed priority (index 0 first), or round-robin
// starting at ptr when PLOT_ARB_RR_EN is defined.
module plot_arb_pick
  import plot_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = cnt_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifdef PLOT_ARB_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

`ifdef PLOT_ARB_RR_EN
  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[k]) begin
        valid    = 1'b1;
        idx      = IDX_W'(k);
        grant[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates drawing requesters and sweeps a TILE_W x TILE_H block into the
// framebuffer. Define PLOT_ARB_RR_EN for round-robin instead of fixed priority.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TILE_W  = PLOT_TILE_W,
  parameter int TILE_H  = PLOT_TILE_H,
  parameter int X_W     = PLOT_X_W,
  parameter int Y_W     = PLOT_Y_W,
  parameter int COLOR_W = PLOT_COLOR_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*X_W-1:0]   req_x,
  input  logic [NREQ*Y_W-1:0]   req_y,
  input  logic [NREQ*COLOR_W-1:0] req_color,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  plot,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [COLOR_W-1:0]    color_out
);

  localparam int IDX_W = cnt_width(NREQ);
  localparam int CW    = cnt_width(TILE_W);
  localparam int RW    = cnt_width(TILE_H);

  plot_state_t        state, state_next;
  logic [NREQ-1:0]    grant_q;
  logic [X_W-1:0]     org_x;
  logic [Y_W-1:0]     org_y;
  logic [COLOR_W-1:0] color_q;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [NREQ-1:0]    pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               col_last;
  logic               last_pixel;

`ifdef PLOT_ARB_RR_EN
  logic [IDX_W-1:0]   ptr;
`endif

  plot_arb_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
`ifdef PLOT_ARB_RR_EN
    .ptr   (ptr),
`endif
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign col_last   = (col == CW'(TILE_W - 1));
  assign last_pixel = col_last && (row == RW'(TILE_H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_next = ST_SWEEP;
      ST_SWEEP: if (last_pixel) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Origin and color are captured only at grant time so requester inputs may change mid-sweep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q <= '0;
      org_x   <= '0;
      org_y   <= '0;
      color_q <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_grant;
            org_x   <= req_x[pick_idx*X_W +: X_W];
            org_y   <= req_y[pick_idx*Y_W +: Y_W];
            color_q <= req_color[pick_idx*COLOR_W +: COLOR_W];
            col     <= '0;
            row     <= '0;
          end
        end
        ST_SWEEP: begin
          if (last_pixel) begin
            col <= '0;
            row <= '0;
          end else if (col_last) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PLOT_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (state == ST_IDLE && pick_valid) begin
      ptr <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  assign plot      = (state == ST_SWEEP);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) ? grant_q : '0;
  assign x_out     = plot ? org_x + X_W'(col) : '0;
  assign y_out     = plot ? org_y + Y_W'(row) : '0;
  assign color_out = plot ? color_q : '0;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter; expectations follow PLOT_ARB_RR_EN.
module tb_plot_arbiter;

  localparam int NREQ    = 3;
  localparam int TILE_W  = 4;
  localparam int TILE_H  = 4;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;
  localparam int PIX_W   = 1 + X_W + Y_W + COLOR_W;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NREQ-1:0]          req;
  logic [NREQ*X_W-1:0]      req_x;
  logic [NREQ*Y_W-1:0]      req_y;
  logic [NREQ*COLOR_W-1:0]  req_color;
  logic [NREQ-1:0]          done;
  logic                     busy;
  logic                     plot;
  logic [X_W-1:0]           x_out;
  logic [Y_W-1:0]           y_out;
  logic [COLOR_W-1:0]       color_out;
  logic [PIX_W-1:0]         pix_obs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  plot_arbiter #(
    .NREQ(NREQ), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .done(done), .busy(busy), .plot(plot),
    .x_out(x_out), .y_out(y_out), .color_out(color_out)
  );

  always #5 clk = ~clk;

  assign pix_obs = {plot, x_out, y_out, color_out};

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c);
    req_x[i*X_W +: X_W]             = X_W'(x);
    req_y[i*Y_W +: Y_W]             = Y_W'(y);
    req_color[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
  endtask

  task automatic test_reset;
    resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_color = '0;
    #3;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (plot !== 1'b0) $display("[TB] FAIL reset_plot: got %b expected 0", plot); else pass_cnt++;
    total_cnt++; if (done !== 3'b000) $display("[TB] FAIL reset_done: got %b expected 000", done); else pass_cnt++;
    total_cnt++; if ({x_out, y_out, color_out} !== '0)
      $display("[TB] FAIL reset_pixel: got x=%0d y=%0d c=%0d expected 0", x_out, y_out, color_out); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();
    next_cycle();
    total_cnt++; if ({busy, plot} !== 2'b00) $display("[TB] FAIL idle_no_req: got busy,plot=%b expected 00", {busy, plot}); else pass_cnt++;
  endtask

  task automatic test_single;
    logic [PIX_W-1:0] exp_pix;
    set_req(0, 10, 20, 5);
    req = 3'b001;
    total_cnt++; if (plot !== 1'b0) $display("[TB] FAIL single_preedge_plot: got %b expected 0", plot); else pass_cnt++;
    next_cycle();
    for (int p = 0; p < TILE_W*TILE_H; p++) begin
      exp_pix = {1'b1, X_W'(10 + p % TILE_W), Y_W'(20 + p / TILE_W), COLOR_W'(5)};
      total_cnt++; if (pix_obs !== exp_pix || done !== 3'b000)
        $display("[TB] FAIL single_pix%0d: got %h done=%b expected %h done=000", p, pix_obs, done, exp_pix); else pass_cnt++;
      next_cycle();
    end
    total_cnt++; if ({done, plot, busy} !== 5'b001_0_1)
      $display("[TB] FAIL single_done: got done,plot,busy=%b expected 00101", {done, plot, busy}); else pass_cnt++;
    req = '0;
    next_cycle();
    total_cnt++; if ({done, busy} !== 4'b000_0)
      $display("[TB] FAIL single_after: got done,busy=%b expected 0000", {done, busy}); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [PIX_W-1:0] exp_pix;
    set_req(0, 254, 126, 6);
    req = 3'b001;
    next_cycle();
    for (int p = 0; p < TILE_W*TILE_H; p++) begin
      exp_pix = {1'b1, X_W'(254 + p % TILE_W), Y_W'(126 + p / TILE_W), COLOR_W'(6)};
      total_cnt++; if (pix_obs !== exp_pix)
        $display("[TB] FAIL wrap_pix%0d: got %h expected %h", p, pix_obs, exp_pix); else pass_cnt++;
      next_cycle();
    end
    total_cnt++; if (done !== 3'b001) $display("[TB] FAIL wrap_done: got %b expected 001", done); else pass_cnt++;
    req = '0;
    next_cycle();
  endtask

  task automatic test_hold_inputs;
    logic [PIX_W-1:0] exp_pix;
    set_req(0, 10, 20, 3);
    req = 3'b001;
    next_cycle();
    for (int p = 0; p < TILE_W*TILE_H; p++) begin
      exp_pix = {1'b1, X_W'(10 + p % TILE_W), Y_W'(20 + p / TILE_W), COLOR_W'(3)};
      total_cnt++; if (pix_obs !== exp_pix)
        $display("[TB] FAIL hold_pix%0d: got %h expected %h", p, pix_obs, exp_pix); else pass_cnt++;
      if (p == 4) set_req(0, 50, 90, 1);
      next_cycle();
    end
    total_cnt++; if (done !== 3'b001) $display("[TB] FAIL hold_done: got %b expected 001", done); else pass_cnt++;
    req = '0;
    next_cycle();
  endtask

  task automatic test_req_drop;
    logic [PIX_W-1:0] exp_pix;
    set_req(0, 30, 40, 7);
    req = 3'b001;
    next_cycle();
    for (int p = 0; p < TILE_W*TILE_H; p++) begin
      exp_pix = {1'b1, X_W'(30 + p % TILE_W), Y_W'(40 + p / TILE_W), COLOR_W'(7)};
      total_cnt++; if (pix_obs !== exp_pix)
        $display("[TB] FAIL drop_pix%0d: got %h expected %h", p, pix_obs, exp_pix); else pass_cnt++;
      if (p == 2) req = '0;
      next_cycle();
    end
    total_cnt++; if (done !== 3'b001) $display("[TB] FAIL drop_done: got %b expected 001", done); else pass_cnt++;
    next_cycle();
    next_cycle();
    total_cnt++; if ({busy, plot} !== 2'b00) $display("[TB] FAIL drop_idle: got busy,plot=%b expected 00", {busy, plot}); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    set_req(0, 10, 20, 5);
    req = 3'b001;
    next_cycle();
    for (int p = 0; p < 7; p++) begin
      total_cnt++; if (pix_obs !== {1'b1, X_W'(10 + p % TILE_W), Y_W'(20 + p / TILE_W), COLOR_W'(5)})
        $display("[TB] FAIL rmid_pix%0d: got %h", p, pix_obs); else pass_cnt++;
      if (p < 6) next_cycle();
    end
    resetn = 1'b0;
    #1;
    total_cnt++; if ({plot, busy, done} !== 5'b0) $display("[TB] FAIL rmid_async: got plot,busy,done=%b expected 00000", {plot, busy, done}); else pass_cnt++;
    #2;
    resetn = 1'b1;
    next_cycle();
    total_cnt++; if (pix_obs !== {1'b1, X_W'(10), Y_W'(20), COLOR_W'(5)})
      $display("[TB] FAIL rmid_restart: got %h expected first pixel (10,20)", pix_obs); else pass_cnt++;
    n = 1;
    for (int w = 0; w < 40; w++) begin
      next_cycle();
      if (done !== 3'b000 || plot !== 1'b1) break;
      n++;
    end
    total_cnt++; if (n !== 16 || done !== 3'b001)
      $display("[TB] FAIL rmid_complete: got %0d plots done=%b expected 16 done=001", n, done); else pass_cnt++;
    req = '0;
    next_cycle();
  endtask

  task automatic test_arbitration;
    int order [4];
    int n;
    logic [NREQ-1:0] exp_done;
`ifdef PLOT_ARB_RR_EN
    order = '{0, 1, 2, 0};
`else
    order = '{0, 0, 0, 0};
`endif
    resetn = 1'b0; #2; resetn = 1'b1;
    set_req(0, 0, 0, 1); set_req(1, 40, 10, 2); set_req(2, 80, 20, 3);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      for (int w = 0; w < 6 && plot !== 1'b1; w++) next_cycle();
      total_cnt++; if (plot !== 1'b1 || x_out !== X_W'(40*order[g]) || color_out !== COLOR_W'(order[g] + 1))
        $display("[TB] FAIL arb_grant%0d: got plot=%b x=%0d c=%0d expected x=%0d c=%0d",
                 g, plot, x_out, color_out, 40*order[g], order[g] + 1); else pass_cnt++;
      n = 0;
      for (int w = 0; w < 40 && plot === 1'b1; w++) begin n++; next_cycle(); end
      exp_done = NREQ'(1) << order[g];
      total_cnt++; if (n !== 16 || done !== exp_done)
        $display("[TB] FAIL arb_done%0d: got %0d plots done=%b expected 16 done=%b", g, n, done, exp_done); else pass_cnt++;
      if (g == 3) req = '0;
      next_cycle();
    end
    resetn = 1'b0; #2; resetn = 1'b1;
    req = 3'b110;
    for (int w = 0; w < 6 && plot !== 1'b1; w++) next_cycle();
    total_cnt++; if (plot !== 1'b1 || x_out !== X_W'(40))
      $display("[TB] FAIL arb_skip0: got plot=%b x=%0d expected requester 1 x=40", plot, x_out); else pass_cnt++;
    for (int w = 0; w < 40 && plot === 1'b1; w++) next_cycle();
    total_cnt++; if (done !== 3'b010) $display("[TB] FAIL arb_skip0_done: got %b expected 010", done); else pass_cnt++;
    req = '0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_hold_inputs();
    test_req_drop();
    test_reset_mid();
    test_arbitration();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
